// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the 16-bit multicycle CPU
package cpu_pkg;
  localparam int WORD_W = 16;
  localparam int DEFAULT_RESET_PC = 0;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, WAIT = 2'd2, VALID = 2'd3} fetch_state_e;
endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter with redirect load and handshake increment
module fetch_pc #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);
  // load beats increment so a redirect on a handshake cycle takes the target
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= RESET_PC;
    else if (load) pc <= load_addr;
    else if (inc) pc <= pc + ADDR_W'(1);
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetches instruction words and presents them under valid/ready
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_data,
  output logic [WORD_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr
);
  fetch_state_e state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic hs;
  assign hs = state == VALID && instr_ready;
  assign instr_valid = state == VALID;
  assign mem_addr = pc;
  fetch_pc #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .reset(reset),
    .load(redirect),
    .inc(hs),
    .load_addr(redirect_addr),
    .pc(pc)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state: redirect and handshake both resample fetch_en
  always_comb begin
    state_nx = state;
    state_nx = redirect          ? (fetch_en ? FETCH : IDLE) :
               state == IDLE     ? (fetch_en ? FETCH : IDLE) :
               state == FETCH    ? WAIT :
               state == WAIT     ? VALID :
               instr_ready       ? (fetch_en ? FETCH : IDLE) : VALID;
  end
  // capture the returned word in WAIT unless a redirect discards it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      instr    <= '0;
      instr_pc <= '0;
    end else if (!redirect && state == WAIT) begin
      instr    <= mem_data;
      instr_pc <= pc;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table, directed and random checks of instr_fetch against a fetch model
module tb_instr_fetch;
  logic clk = 0, reset = 1, fetch_en = 0, instr_ready = 0, redirect = 0;
  logic [15:0] mem_addr, mem_data, instr, instr_pc, redirect_addr;
  logic instr_valid;
  logic [15:0] mem [0:65535];
  int n_vec = 0, n_bad = 0;
  logic [15:0] m_pc, m_instr, m_ipc;
  logic m_valid, m_parked;
  int m_cnt;
  typedef struct {logic fe; logic rdy; logic v; logic [15:0] i; logic [15:0] p; logic [15:0] a;} vec_t;
  vec_t tbl [15];

  instr_fetch dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_addr(redirect_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {15'b0, instr_valid, instr, instr_pc, mem_addr};
  endfunction

  task automatic m_reset();
    m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_parked = 1; m_cnt = 0;
  endtask

  // an instruction appears two cycles after a fetch begins; redirect or accept restarts
  task automatic m_step();
    if (redirect) begin
      m_pc = redirect_addr; m_valid = 0; m_parked = !fetch_en; m_cnt = 0;
    end else if (m_valid) begin
      if (instr_ready) begin
        m_pc = m_pc + 16'd1; m_valid = 0; m_parked = !fetch_en; m_cnt = 0;
      end
    end else if (m_parked) begin
      if (fetch_en) begin m_parked = 0; m_cnt = 0; end
    end else if (m_cnt == 1) begin
      m_valid = 1; m_instr = mem[m_pc]; m_ipc = m_pc;
    end else m_cnt++;
  endtask

  task automatic step();
    m_step();
    @(posedge clk);
    #1;
    chk("model", dut_vec(), {15'b0, m_valid, m_instr, m_ipc, m_pc});
  endtask

  task automatic drive(input logic fe, input logic rdy, input logic rd, input logic [15:0] ra);
    fetch_en = fe; instr_ready = rdy; redirect = rd; redirect_addr = ra;
  endtask

  initial begin
    for (int k = 0; k < 65536; k++) mem[k] = 16'($urandom);
    mem[0] = 16'h0123; mem[1] = 16'h4A5B; mem[2] = 16'hF00D; mem[16'h40] = 16'hBEEF;
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0},
      '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0, 16'h0},
      '{1'b1, 1'b0, 1'b1, 16'h0123, 16'h0, 16'h0},
      '{1'b1, 1'b0, 1'b1, 16'h0123, 16'h0, 16'h0},
      '{1'b1, 1'b0, 1'b1, 16'h0123, 16'h0, 16'h0},
      '{1'b1, 1'b0, 1'b1, 16'h0123, 16'h0, 16'h0},
      '{1'b1, 1'b0, 1'b1, 16'h0123, 16'h0, 16'h0},
      '{1'b1, 1'b0, 1'b1, 16'h0123, 16'h0, 16'h0},
      '{1'b1, 1'b1, 1'b0, 16'h0123, 16'h0, 16'h1},
      '{1'b1, 1'b1, 1'b0, 16'h0123, 16'h0, 16'h1},
      '{1'b1, 1'b1, 1'b1, 16'h4A5B, 16'h1, 16'h1},
      '{1'b1, 1'b1, 1'b0, 16'h4A5B, 16'h1, 16'h2},
      '{1'b1, 1'b1, 1'b0, 16'h4A5B, 16'h1, 16'h2},
      '{1'b1, 1'b1, 1'b1, 16'hF00D, 16'h2, 16'h2},
      '{1'b1, 1'b1, 1'b0, 16'hF00D, 16'h2, 16'h3}
    };
    m_reset();
    drive(1, 0, 0, 0);
    #2;
    chk("reset_state", dut_vec(), 64'h0);
    #10 reset = 0;
    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].fe, tbl[k].rdy, 0, 0);
      step();
      chk($sformatf("tbl%0d", k), dut_vec(), {15'b0, tbl[k].v, tbl[k].i, tbl[k].p, tbl[k].a});
    end
    drive(1, 0, 0, 0); step();
    drive(1, 0, 1, 16'h0040); step();
    chk("redir_wait_valid", {63'b0, instr_valid}, 64'h0);
    chk("redir_wait_addr", {48'b0, mem_addr}, 64'h40);
    drive(1, 0, 0, 0); step(); step();
    chk("redir_target", {15'b0, instr_valid, instr, instr_pc, 16'h0}, {15'b0, 1'b1, 16'hBEEF, 16'h0040, 16'h0});
    drive(1, 1, 1, 16'h0010); step();
    chk("hs_redir_addr", {47'b0, instr_valid, mem_addr}, {47'b0, 1'b0, 16'h0010});
    drive(1, 0, 0, 0); step(); step();
    chk("hs_redir_pc", {47'b0, instr_valid, instr_pc}, {47'b0, 1'b1, 16'h0010});
    drive(1, 0, 1, 16'hFFFF); step();
    drive(1, 0, 0, 0); step(); step();
    chk("wrap_pc", {47'b0, instr_valid, instr_pc}, {47'b0, 1'b1, 16'hFFFF});
    drive(1, 1, 0, 0); step();
    chk("wrap_addr", {48'b0, mem_addr}, 64'h0);
    drive(1, 0, 0, 0); step(); step();
    chk("pre_areset_valid", {63'b0, instr_valid}, 64'h1);
    #2 reset = 1;
    #1;
    m_reset();
    chk("areset_clear", dut_vec(), 64'h0);
    #1 reset = 0;
    drive(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) step();
    chk("idle_parked", {47'b0, instr_valid, mem_addr}, 64'h0);
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom));
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
